// File: rtl/alu_exec_seq.sv
// Five-state execute sequencer that feeds an external 16-bit ALU. It reads operands
// from an internal 8x16 register file, captures the ALU result and flags, and writes back.
module alu_exec_seq #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_compare,
  input  logic             alu_carry_out,
  output logic             done,
  output logic             flag_eq,
  output logic             flag_c,
  output logic             illegal,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXE, WB} state_t;
  typedef enum logic [1:0] {OP_ALU = 2'b00, OP_LDI = 2'b01, OP_CMP = 2'b10, OP_RSV = 2'b11} op_t;

  state_t           state_q, state_d;
  logic [15:0]      instr_q;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] regs [NREGS];

  logic [2:0] rx, ry;
  op_t        op;
  logic       writes_back;
  logic [1:0] unused_bits;

  assign rx          = instr_q[15:13];
  assign ry          = instr_q[12:10];
  assign op          = op_t'(instr_q[1:0]);
  assign writes_back = (op == OP_ALU) || (op == OP_LDI);
  // Bits [3:2] carry no meaning in the instruction format.
  assign unused_bits = instr_q[3:2];

  assign instr_ready = (state_q == IDLE);
  assign dbg_data    = regs[dbg_addr];

  // NOTE: state register and next-state logic are split so the combinational
  // half can assign a default first and never infer a latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = RDA;
      RDA:     state_d = RDB;
      RDB:     state_d = EXE;
      EXE:     state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the register file is small and must read as zero after reset, so every
  // entry is reset explicitly; larger memories would normally be left unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      instr_q      <= '0;
      res          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      flag_eq      <= 1'b0;
      flag_c       <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) instr_q <= instr;
        RDA: begin
          alu_a        <= regs[rx];
          alu_select   <= instr_q[9:6];
          alu_mode     <= instr_q[5];
          alu_carry_in <= instr_q[4];
        end
        RDB: alu_b <= regs[ry];
        EXE: begin
          case (op)
            OP_ALU, OP_CMP: begin
              res     <= alu_result;
              flag_eq <= alu_compare;
              flag_c  <= alu_carry_out;
            end
            OP_LDI:  res <= {{(WIDTH-8){1'b0}}, instr_q[12:5]};
            default: ;
          endcase
        end
        WB: begin
          if (writes_back) regs[rx] <= res;
          // Pulses are registered so they appear in the cycle after the WB edge.
          done    <= 1'b1;
          illegal <= (op == OP_RSV);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq; a small behavioural ALU closes the loop on the alu_* ports.
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry_in, alu_compare, alu_carry_out;
  logic        done, flag_eq, flag_c, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_mode     (alu_mode),
    .alu_carry_in (alu_carry_in),
    .alu_result   (alu_result),
    .alu_compare  (alu_compare),
    .alu_carry_out(alu_carry_out),
    .done         (done),
    .flag_eq      (flag_eq),
    .flag_c       (flag_c),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU: add for mode0/1001, NOT a for mode1/0000, xor otherwise.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_carry_in};
    alu_result    = alu_a ^ alu_b;
    alu_carry_out = 1'b0;
    if (!alu_mode && alu_select == 4'b1001) begin
      alu_result    = alu_sum[15:0];
      alu_carry_out = alu_sum[16];
    end else if (alu_mode && alu_select == 4'b0000) begin
      alu_result = ~alu_a;
    end
    alu_compare = (alu_a == alu_b);
  end

  localparam logic [15:0] LDI_R1_12  = (16'd1 << 13) | (16'h12 << 5) | 16'd1;
  localparam logic [15:0] LDI_R2_34  = (16'd2 << 13) | (16'h34 << 5) | 16'd1;
  localparam logic [15:0] LDI_R4_56  = (16'd4 << 13) | (16'h56 << 5) | 16'd1;
  localparam logic [15:0] ADD_R1_R2  = (16'd1 << 13) | (16'd2 << 10) | (16'd9 << 6);
  localparam logic [15:0] CMP_R2_R2  = (16'd2 << 13) | (16'd2 << 10) | (16'd9 << 6) | 16'd2;
  localparam logic [15:0] NOT_R3     = (16'd3 << 13) | (16'd3 << 10) | (16'd1 << 5);
  localparam logic [15:0] RSV_R5     = (16'd5 << 13) | (16'd5 << 10) | (16'd9 << 6) | 16'd3;

  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    dbg_addr = idx;
    #1 val = dbg_data;
  endtask

  // Issues one instruction and watches 8 cycles after the handshake edge.
  task automatic run_instr(input logic [15:0] word, output int lat, output int ndone,
                           output int nill, output bit ill_with_done);
    lat = -1; ndone = 0; nill = 0; ill_with_done = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 10 && !instr_ready; w++) @(negedge clk);
    instr       = word;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'hDEAD;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (lat < 0) lat = c;
        ndone++;
      end
      if (illegal) nill++;
      if (illegal && done) ill_with_done = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    n_checks++; if ({flag_eq, flag_c} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {flag_eq, flag_c}); end
    n_checks++; if ({alu_a, alu_b} !== 32'h0) begin n_fail++; $display("FAIL reset_alu_ab: got %h expected 0", {alu_a, alu_b}); end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), v);
      n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0000", i, v); end
    end
  endtask

  task automatic test_ldi;
    int lat, nd, ni; bit iwd; logic [15:0] v;
    run_instr(LDI_R1_12, lat, nd, ni, iwd);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ldi1_latency: got %0d expected 4", lat); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ldi1_done_count: got %0d expected 1", nd); end
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h0012) begin n_fail++; $display("FAIL ldi_r1: got %h expected 0012", v); end
    run_instr(LDI_R2_34, lat, nd, ni, iwd);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ldi2_latency: got %0d expected 4", lat); end
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h0034) begin n_fail++; $display("FAIL ldi_r2: got %h expected 0034", v); end
    n_checks++; if (flag_eq !== 1'b0) begin n_fail++; $display("FAIL ldi_flag_eq: got %b expected 0", flag_eq); end
  endtask

  task automatic test_alu_add;
    int lat, nd, ni; bit iwd; logic [15:0] v;
    run_instr(ADD_R1_R2, lat, nd, ni, iwd);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d expected 4", lat); end
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h0046) begin n_fail++; $display("FAIL add_r1: got %h expected 0046", v); end
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h0034) begin n_fail++; $display("FAIL add_r2: got %h expected 0034", v); end
    n_checks++; if ({flag_eq, flag_c} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b expected 00", {flag_eq, flag_c}); end
    n_checks++; if ({alu_select, alu_mode} !== 5'b10010) begin n_fail++; $display("FAIL add_alu_ctrl: got %b expected 10010", {alu_select, alu_mode}); end
  endtask

  task automatic test_cmp;
    int lat, nd, ni; bit iwd; logic [15:0] v;
    run_instr(CMP_R2_R2, lat, nd, ni, iwd);
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL cmp_done_count: got %0d expected 1", nd); end
    n_checks++; if (flag_eq !== 1'b1) begin n_fail++; $display("FAIL cmp_flag_eq: got %b expected 1", flag_eq); end
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h0034) begin n_fail++; $display("FAIL cmp_r2: got %h expected 0034", v); end
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h0046) begin n_fail++; $display("FAIL cmp_r1: got %h expected 0046", v); end
  endtask

  // instr_valid held high across two instructions; instr is garbage while not ready.
  task automatic test_back_to_back;
    logic [15:0] prog [2];
    int acc_cycle [2];
    int n_acc, n_ill;
    logic [15:0] v;
    prog[0] = NOT_R3;
    prog[1] = LDI_R4_56;
    n_acc = 0; n_ill = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      instr = instr_ready ? prog[n_acc] : 16'hFFFF;
      if (instr_ready) begin
        acc_cycle[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
      if (illegal) n_ill++;
    end
    instr_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (illegal) n_ill++;
    end
    n_checks++; if (n_acc !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
    n_checks++; if (n_acc == 2 && acc_cycle[1] - acc_cycle[0] !== 5) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 5", acc_cycle[1] - acc_cycle[0]); end
    read_reg(3'd3, v);
    n_checks++; if (v !== 16'hFFFF) begin n_fail++; $display("FAIL not_r3: got %h expected ffff", v); end
    read_reg(3'd4, v);
    n_checks++; if (v !== 16'h0056) begin n_fail++; $display("FAIL b2b_r4: got %h expected 0056", v); end
    n_checks++; if (n_ill !== 0) begin n_fail++; $display("FAIL b2b_illegal: got %0d expected 0", n_ill); end
    n_checks++; if (flag_eq !== 1'b1) begin n_fail++; $display("FAIL not_flag_eq: got %b expected 1", flag_eq); end
  endtask

  task automatic test_illegal;
    int lat, nd, ni; bit iwd; logic [15:0] v;
    run_instr(RSV_R5, lat, nd, ni, iwd);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ill_latency: got %0d expected 4", lat); end
    n_checks++; if (iwd !== 1'b1) begin n_fail++; $display("FAIL ill_with_done: got %b expected 1", iwd); end
    n_checks++; if (ni !== 1) begin n_fail++; $display("FAIL ill_count: got %0d expected 1", ni); end
    read_reg(3'd5, v);
    n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL ill_r5: got %h expected 0000", v); end
    n_checks++; if ({flag_eq, flag_c} !== 2'b10) begin n_fail++; $display("FAIL ill_flags: got %b expected 10", {flag_eq, flag_c}); end
  endtask

  task automatic test_reset_abort;
    int nd; logic [15:0] v;
    nd = 0;
    @(negedge clk);
    instr       = ADD_R1_R2;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", instr_ready); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", nd); end
    read_reg(3'd1, v);
    n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL abort_r1: got %h expected 0000", v); end
    read_reg(3'd2, v);
    n_checks++; if (v !== 16'h0000) begin n_fail++; $display("FAIL abort_r2: got %h expected 0000", v); end
    n_checks++; if (flag_eq !== 1'b0) begin n_fail++; $display("FAIL abort_flag_eq: got %b expected 0", flag_eq); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    dbg_addr    = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_ldi();
    test_alu_add();
    test_cmp();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer that sits directly upstream of the 16-bit ALU and feeds it.
- Accepts one 16-bit instruction per transaction over a valid/ready handshake.
- Reads operands from an internal 8x16 register file, drives the ALU's in_a/in_b/select/mode/carry_in from registered values, and captures alu_out.
- Writes the result back to the register file and raises a one-cycle done pulse.

Parameters:
- NREGS, 8, number of register-file entries (index width 3; fixed by instruction format).
- WIDTH, 16, datapath width; must match the ALU.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- instr  input  16  instruction word, sampled on handshake
- instr_valid  input  1  instr is valid
- instr_ready  output  1  sequencer can accept (high only in IDLE)
- alu_a  output  16  to ALU in_a (registered)
- alu_b  output  16  to ALU in_b (registered)
- alu_select  output  4  to ALU select (registered)
- alu_mode  output  1  to ALU mode, 1=logic, 0=arithmetic (registered)
- alu_carry_in  output  1  to ALU carry_in (registered)
- alu_result  input  16  from ALU alu_out
- alu_compare  input  1  from ALU compare
- alu_carry_out  input  1  from ALU carry_out
- done  output  1  one-cycle pulse when the instruction retires
- flag_eq  output  1  last captured compare flag
- flag_c  output  1  last captured carry flag
- illegal  output  1  one-cycle pulse, reserved opcode retired
- dbg_addr  input  3  debug read index
- dbg_data  output  16  combinational read of regfile[dbg_addr]

Behaviour:
Instruction fields:
- [15:13] rx: destination and operand A.
- [12:10] ry: operand B.
- [9:6] select; [5] mode; [4] carry_in; [1:0] op.
- Imm8 = instr[12:5] for LDI.
- op encoding:
  - 00 ALU: rx <= alu(rx, ry).
  - 01 LDI: rx <= {8'h00, imm8}; ALU not used.
  - 10 CMP: ALU runs, flags update, no writeback.
  - 11 reserved: no writeback, illegal pulse.

States:
- IDLE: instr_ready=1. On instr_valid, latch instr and go to RDA. Without valid, stay.
- RDA: a_reg <= regfile[rx]; select/mode/carry_in regs loaded from instr; go to RDB.
- RDB: b_reg <= regfile[ry]; go to EXE.
- EXE: ALU inputs are stable from registers.
  - For ALU/CMP ops: capture res <= alu_result, flag_eq <= alu_compare, flag_c <= alu_carry_out.
  - For LDI: res <= zero-extended imm8; flags unchanged.
  - For reserved: nothing captured.
  - Go to WB.
- WB:
  - ALU/LDI: regfile[rx] <= res.
  - CMP and reserved: no write.
  - done=1 for this cycle only; illegal=1 in this cycle only if op==11.
  - Return to IDLE.

Timing and rules:
- Latency: handshake at edge N, done high in the cycle after edge N+4; the written register is visible on dbg_data in the next cycle.
- Throughput: one instruction per 5 cycles.
- instr_ready is 0 in every non-IDLE state; instr_valid is ignored there, and instr may change without effect.
- alu_* outputs hold their last values outside RDA..EXE; no glitch requirement beyond registered outputs.
- rx==ry is legal: both operands read the same pre-write value.
- Register 0 is an ordinary register (not hardwired zero).
- Flags persist until the next ALU/CMP capture.

Reset (asynchronous, reset_n=0):
- State goes to IDLE.
- All regfile entries, a_reg, b_reg, res, and alu_* outputs go to 0.
- done, illegal, flag_eq, flag_c go to 0.
- instr_ready goes to 1 once reset_n=1.
- Reset mid-operation aborts with no writeback and no done pulse.

Test Plan:
- LDI R1 imm 0x12, then LDI R2 imm 0x34 -> done 4 cycles after each handshake; dbg R1=0x0012, R2=0x0034.
- ALU R1,R2, select 1001, mode 0 (add) -> R1=0x0046; flag_eq=0; R2 unchanged.
- CMP R2,R2 -> flag_eq=1, R2 still 0x0034, no register changes, done pulses once.
- ALU R3,R3, select 0000, mode 1 (NOT) with R3=0 -> R3=0xFFFF; instr_valid held high throughout accepts exactly one instruction per 5 cycles.
- op=11 -> illegal and done pulse together; no register or flag changes.
- Assert reset_n low during EXE of an ALU op targeting R1=0x0046 -> R1=0x0000, no done pulse, instr_ready=1 after release.
